// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch and load/store; data wins unless fetch is starved.
// Optional MEM_PORT_ARBITER_STATS_EN adds ack/wait statistics counters.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
`ifdef MEM_PORT_ARBITER_STATS_EN
  output logic [31:0]       stat_if_cnt,
  output logic [31:0]       stat_d_cnt,
  output logic [31:0]       stat_wait_cnt,
`endif
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       starved;
  logic       grant_d;
  logic       grant_i;

  always_comb begin
    starved = if_req && (starve_cnt == LIMIT);
    grant_d = d_req && !starved;
    grant_i = if_req && !grant_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner      <= 2'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= BUSY_D;
            owner     <= 2'd2;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            // Only data grants that make a pending fetch wait count toward starvation.
            if (if_req && starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + 4'd1;
          end else if (grant_i) begin
            state      <= BUSY_I;
            owner      <= 2'd1;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_be     <= 4'hF;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_rdata <= mem_rdata;
            if_ack   <= 1'b1;
            state    <= DONE;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we)
              d_rdata <= mem_rdata;
            d_ack   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          // No grant here: the requester gets this cycle to retire its old request.
          state <= IDLE;
          owner <= 2'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic waiting;

  always_comb begin
    waiting = ((state != IDLE) && (if_req || d_req)) ||
              ((state == IDLE) && if_req && d_req);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_if_cnt   <= '0;
      stat_d_cnt    <= '0;
      stat_wait_cnt <= '0;
    end else begin
      if (if_ack)  stat_if_cnt   <= stat_if_cnt + 32'd1;
      if (d_ack)   stat_d_cnt    <= stat_d_cnt + 32'd1;
      if (waiting) stat_wait_cnt <= stat_wait_cnt + 32'd1;
    end
  end
`endif

endmodule
